// File: rtl/wb_ram_arbiter.sv
// wb_ram_arbiter: two-master round-robin Wishbone classic arbiter in front of one wb_ram slave,
// with a per-grant watchdog that turns a missing ack into a one-cycle error.
module wb_ram_arbiter #(
    parameter int AW      = 7,
    parameter int TIMEOUT = 15
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [3:0]    m0_be_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [31:0]   m0_dat_i,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    output logic [31:0]   m0_dat_o,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [3:0]    m1_be_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [31:0]   m1_dat_i,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic [31:0]   m1_dat_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [3:0]    s_be_o,
    output logic [AW-1:0] s_adr_o,
    output logic [31:0]   s_dat_o,
    input  logic          s_ack_i,
    input  logic [31:0]   s_dat_i
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
    state_t state_q, state_d;
    logic last_q, last_d;
    logic [7:0] to_cnt_q, to_cnt_d;
    logic g0, g1, m0_req, m1_req, cyc_sel, expire;
    assign m0_req  = m0_cyc_i & m0_stb_i;
    assign m1_req  = m1_cyc_i & m1_stb_i;
    assign g0      = state_q == GNT0;
    assign g1      = state_q == GNT1;
    assign cyc_sel = g0 ? m0_cyc_i : m1_cyc_i;
    assign expire  = to_cnt_q == 8'(TIMEOUT - 1);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            to_cnt_q <= to_cnt_d;
        end
    end
    // the counter free-runs while granted; entry from IDLE always restarts it at 0
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        to_cnt_d = to_cnt_q + 8'd1;
        if (state_q == IDLE) begin
            to_cnt_d = '0;
            if (m0_req && (!m1_req || last_q)) begin
                state_d = GNT0;
                last_d  = 1'b0;
            end else if (m1_req) begin
                state_d = GNT1;
                last_d  = 1'b1;
            end
        end else if (s_ack_i || !cyc_sel || expire) begin
            state_d = IDLE;
        end
    end
    assign s_cyc_o  = g0 ? m0_cyc_i : g1 & m1_cyc_i;
    assign s_stb_o  = g0 ? m0_stb_i : g1 & m1_stb_i;
    assign s_we_o   = g0 ? m0_we_i  : g1 & m1_we_i;
    assign s_be_o   = g0 ? m0_be_i  : g1 ? m1_be_i  : '0;
    assign s_adr_o  = g0 ? m0_adr_i : g1 ? m1_adr_i : '0;
    assign s_dat_o  = g0 ? m0_dat_i : g1 ? m1_dat_i : '0;
    assign m0_ack_o = g0 & s_ack_i;
    assign m1_ack_o = g1 & s_ack_i;
    assign m0_err_o = g0 & m0_cyc_i & ~s_ack_i & expire;
    assign m1_err_o = g1 & m1_cyc_i & ~s_ack_i & expire;
    assign m0_dat_o = g0 ? s_dat_i : '0;
    assign m1_dat_o = g1 ? s_dat_i : '0;
endmodule

// File: doc/wb_ram_arbiter.md
# wb_ram_arbiter

Two-master round-robin Wishbone classic arbiter that shares one single-port `wb_ram` slave between two requesters, typically the FazyRV instruction and data ports. It registers the grant decision and forwards the granted master's bus to the RAM. It returns the RAM's ack to the granted master only. A per-transfer watchdog converts a missing ack into a one-cycle error and frees the bus.

## Interface
Parameters:
- `AW`, 7, word address width; matches `$clog2(DEPTH)` of the RAM.
- `TIMEOUT`, 15, cycles in a grant state without `s_ack_i` before an error; legal range 2..255.

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i` in 1 each: master 0 Wishbone request.
- `m0_be_i` in 4: master 0 byte enables.
- `m0_adr_i` in AW: master 0 word address.
- `m0_dat_i` in 32: master 0 write data.
- `m0_ack_o` out 1: master 0 acknowledge.
- `m0_err_o` out 1: master 0 timeout error.
- `m0_dat_o` out 32: master 0 read data.
- `m1_*`: identical set for master 1.
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1 each: to RAM.
- `s_be_o` out 4: to RAM.
- `s_adr_o` out AW: to RAM.
- `s_dat_o` out 32: to RAM.
- `s_ack_i` in 1: from RAM.
- `s_dat_i` in 32: from RAM.

## Operation
- **State machine** (registered): IDLE, GNT0, GNT1.
- **Request**: `mX_req = mX_cyc_i & mX_stb_i`.
- **IDLE arbitration**:
  - Only one master requesting: go to that master's GNT state.
  - Both requesting: grant the master other than `last_q`.
  - Neither requesting: stay in IDLE.
  - On every grant, `last_q <= granted index`.
- **Round-robin pointer**: `last_q` resets to 1, so master 0 wins the first tie.
- **Forwarding in GNTx**:
  - `s_cyc_o = mX_cyc_i`, `s_stb_o = mX_stb_i`.
  - `s_we_o`, `s_be_o`, `s_adr_o`, `s_dat_o` copy master X.
  - In IDLE all `s_*` outputs are 0.
- **Ack and data return**:
  - `mX_ack_o = s_ack_i & (state==GNTx)`, combinational.
  - `mX_dat_o = s_dat_i` when `state==GNTx`, else 0.
  - The other master sees ack=0, err=0 and dat=0.
- **Leaving GNTx**: exit to IDLE on whichever comes first:
  1. `s_ack_i` sampled high: transfer done.
  2. `mX_cyc_i` sampled low: abort; no ack or err is delivered.
  3. Watchdog expiry.
- **Watchdog**:
  - `to_cnt` is 8 bits. It clears on entry to GNTx and increments each GNT cycle without ack.
  - When `to_cnt == TIMEOUT-1` and `s_ack_i==0`: `mX_err_o = 1` for that cycle, then go to IDLE.
  - Err and ack are never both high.
- **Stray acks**: `s_ack_i` arriving in IDLE is ignored and not forwarded.
- **Fairness**: one transfer per grant. A master with back-to-back requests alternates with the other master whenever both request.

## Timing
- **Reset**: state=IDLE, `last_q`=1, `to_cnt`=0. All `s_*`, `mX_ack_o`, `mX_err_o` and `mX_dat_o` are 0, asynchronously on `rst_i` assertion. Reset mid-transfer drops `s_stb_o` immediately; no ack is delivered.
- **Read/write latency**, master asserting `cyc`/`stb` in cycle 0 with the bus idle:
  - Cycle 1: GNTx, `s_stb_o=1`.
  - Cycle 2: the RAM returns a registered ack, `mX_ack_o=1` with read data valid.
  - Cycle 3: IDLE.
  - Result: 2 cycles from request to ack, 3-cycle issue interval per master.
- **Back-to-back**: the master drops `stb` in cycle 3 per Wishbone classic. `s_stb_o` is 0 in IDLE, so the RAM's toggling ack cannot produce a duplicate ack.
- **Simultaneous requests**, both in cycle 0: the winner is acked in cycle 2. The loser is granted in cycle 4 (IDLE in cycle 3, grant registered at the end of cycle 3) and acked in cycle 5.
- **Abort**: `cyc` low in GNT cycle k gives IDLE in cycle k+1. An ack arriving in the same cycle k is still forwarded.
- **Timeout**: with no ack, err is asserted in the TIMEOUT-th GNT cycle (cycle TIMEOUT after the request), then IDLE.

## Test plan
- **Single read**: reset, m0 reads adr=5 after a write of 0xDEADBEEF with be=4'hF. Required: `m0_ack_o` 2 cycles after `stb`, `m0_dat_o`=0xDEADBEEF, `m1_ack_o` stays 0.
- **Byte write**: m1 writes 0x000000AA with be=4'b0001 to adr=5, then reads. Required: 0xDEADBEAA.
- **Contention**: both masters raise `stb` in the same cycle, twice in a row. Required grant order m0, m1, m0, m1. Each ack goes only to its owner, and the second master's ack arrives 3 cycles after the first.
- **Abort**: m0 drops `cyc` in cycle 1 of its grant. Required: no `m0_ack_o`, IDLE next cycle, and a pending m1 is granted on the following edge.
- **Timeout**: with TIMEOUT=4 and `s_ack_i` forced 0, m1 requests. Required: `m1_err_o`=1 for exactly one cycle, 4 cycles after `stb`, then IDLE.
- **Reset mid-grant**: assert `rst_i` in GNT0. Required: all outputs 0 in the same cycle, and after release the next tie goes to m0.
